// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux among four requesters; the captured
// word is presented downstream on a valid/ready handshake.
module rr_mux4_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] xfer_cnt
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_n;
  logic [1:0]       ptr, ptr_n, sel_n, winner, idx;
  logic [3:0]       elig, gnt_n;
  logic             found, capture, accept;
  logic [WIDTH-1:0] dmux, data_n;
  logic [CNT_W-1:0] cnt_n;

  // A requester holding its gnt pulse is excluded so it is not granted twice
  // for the same word.
  always_comb begin
    elig   = req & ~gnt;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && elig[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    case (winner)
      2'd0:    dmux = d0;
      2'd1:    dmux = d1;
      2'd2:    dmux = d2;
      default: dmux = d3;
    endcase
  end

  assign accept  = (state == BUSY) && out_ready;
  assign capture = found && ((state == IDLE) || out_ready);

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    sel_n   = sel;
    data_n  = out_data;
    gnt_n   = '0;
    cnt_n   = xfer_cnt;
    if (accept) begin
      cnt_n = xfer_cnt + 1'b1;
    end
    if (capture) begin
      state_n = BUSY;
      sel_n   = winner;
      data_n  = dmux;
      gnt_n   = 4'b0001 << winner;
      ptr_n   = winner + 2'd1;
    end else if (accept) begin
      state_n = IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      sel      <= '0;
      gnt      <= '0;
      out_data <= '0;
      xfer_cnt <= '0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      sel      <= sel_n;
      gnt      <= gnt_n;
      out_data <= data_n;
      xfer_cnt <= cnt_n;
    end
  end

  assign out_valid = (state == BUSY);

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Self-checking bench for rr_mux4_arbiter against a cycle-level reference model.
module tb_rr_mux4_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] d0, d1, d2, d3;
  logic [3:0]  gnt;
  logic [1:0]  sel;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic [3:0]  xfer_cnt;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic        e_valid;
  logic [31:0] e_data;
  int          e_sel, e_ptr, e_cnt, acc;
  logic [3:0]  e_gnt;

  rr_mux4_arbiter #(.WIDTH(32), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .req(req),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .gnt(gnt), .sel(sel), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dpick(int w);
    case (w)
      0:       return d0;
      1:       return d1;
      2:       return d2;
      default: return d3;
    endcase
  endfunction

  function automatic logic [42:0] obs();
    return {out_valid, sel, gnt, out_data, xfer_cnt};
  endfunction

  function automatic logic [42:0] expv();
    return {e_valid, 2'(e_sel), e_gnt, e_data, 4'(e_cnt)};
  endfunction

  task automatic model_reset();
    e_valid = 1'b0; e_data = '0; e_sel = 0; e_gnt = '0; e_ptr = 0; e_cnt = 0;
  endtask

  // Advance the model one clock from the current inputs, then let the DUT clock.
  task automatic tick();
    int w;
    bit acc_now;
    w = -1;
    for (int k = 0; k < 4; k++)
      if (w < 0 && req[(e_ptr + k) % 4] && !e_gnt[(e_ptr + k) % 4]) w = (e_ptr + k) % 4;
    acc_now = e_valid && out_ready;
    if (acc_now) begin
      e_cnt = (e_cnt + 1) % 16;
      acc++;
    end
    if (w >= 0 && (!e_valid || out_ready)) begin
      e_sel = w; e_data = dpick(w); e_valid = 1'b1;
      e_gnt = 4'(1 << w); e_ptr = (w + 1) % 4;
    end else begin
      e_gnt = '0;
      if (acc_now) e_valid = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; #2; reset = 1'b0;
    model_reset();
    acc = 0;
  endtask

  task automatic test_reset();
    req = 4'b0010; d1 = 32'hDEADBEEF; out_ready = 1'b0;
    tick();
    total++;
    if (obs() !== expv() || !out_valid) begin
      bad++; $display("FAIL reset_busy: got %h want %h", obs(), expv());
    end
    #3 reset = 1'b1;
    #1;
    total++;
    if (obs() !== 43'd0) begin
      bad++; $display("FAIL reset_async: got %h want 0", obs());
    end
    req = 4'b0000;
    #1 reset = 1'b0;
    model_reset();
    acc = 0;
    repeat (2) tick();
    total++;
    if (obs() !== 43'd0) begin
      bad++; $display("FAIL reset_after: got %h want 0", obs());
    end
  endtask

  task automatic test_single();
    apply_reset();
    req = 4'b0100; d2 = 32'h12345678; out_ready = 1'b1;
    tick();
    total++;
    if (obs() !== expv() || sel !== 2'd2 || gnt !== 4'b0100 || out_data !== 32'h12345678 || !out_valid) begin
      bad++; $display("FAIL single_cap: got %h want %h", obs(), expv());
    end
    req = 4'b0000;
    tick();
    total++;
    if (obs() !== expv() || xfer_cnt !== 4'd1 || out_valid !== 1'b0 || gnt !== 4'b0000) begin
      bad++; $display("FAIL single_acc: got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    d0 = 32'hA0; d1 = 32'hA1; d2 = 32'hA2; d3 = 32'hA3;
    req = 4'b1111; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      total++;
      if (obs() !== expv() || sel !== 2'(k % 4) || out_data !== 32'hA0 + 32'(k % 4) || xfer_cnt !== 4'(k)) begin
        bad++; $display("FAIL round_robin[%0d]: got %h want %h", k, obs(), expv());
      end
    end
  endtask

  task automatic test_back_pressure();
    apply_reset();
    d3 = 32'hCAFEF00D; d0 = 32'h00000B0B; req = 4'b1000; out_ready = 1'b0;
    tick();
    req = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      tick();
      total++;
      if (obs() !== expv() || sel !== 2'd3 || out_data !== 32'hCAFEF00D || gnt !== 4'b0000 || !out_valid) begin
        bad++; $display("FAIL back_pressure[%0d]: got %h want %h", k, obs(), expv());
      end
    end
    out_ready = 1'b1;
    tick();
    total++;
    if (obs() !== expv() || sel !== 2'd0 || gnt !== 4'b0001 || xfer_cnt !== 4'd1 || out_data !== 32'h00000B0B) begin
      bad++; $display("FAIL bp_release: got %h want %h", obs(), expv());
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_pointer_skip();
    apply_reset();
    d0 = 32'h1000; d1 = 32'h1001; req = 4'b0010; out_ready = 1'b1;
    tick();
    req = 4'b0011;
    tick();
    total++;
    if (obs() !== expv() || sel !== 2'd0 || gnt !== 4'b0001) begin
      bad++; $display("FAIL skip_wrap: got %h want %h", obs(), expv());
    end
    tick();
    total++;
    if (obs() !== expv() || sel !== 2'd1 || gnt !== 4'b0010) begin
      bad++; $display("FAIL skip_next: got %h want %h", obs(), expv());
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_counter_wrap();
    apply_reset();
    req = 4'b0011; out_ready = 1'b1;
    for (int k = 0; k < 40 && acc < 17; k++) begin
      tick();
      total++;
      if (obs() !== expv()) begin
        bad++; $display("FAIL wrap_model[%0d]: got %h want %h", k, obs(), expv());
      end
      if (acc == 15 || acc == 16 || acc == 17) begin
        total++;
        if (xfer_cnt !== 4'(acc % 16)) begin
          bad++; $display("FAIL wrap_cnt acc=%0d: got %0d want %0d", acc, xfer_cnt, acc % 16);
        end
      end
    end
    total++;
    if (acc !== 17) begin
      bad++; $display("FAIL wrap_budget: got %0d accepts want 17", acc);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_random();
    apply_reset();
    for (int k = 0; k < 400; k++) begin
      req = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      d0 = $urandom; d1 = $urandom; d2 = $urandom; d3 = $urandom;
      tick();
      total++;
      if (obs() !== expv()) begin
        bad++; $display("FAIL random[%0d]: got %h want %h", k, obs(), expv());
      end
    end
  endtask

  initial begin
    reset = 1'b1; req = '0; out_ready = 1'b0;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;
    model_reset();
    acc = 0;
    @(posedge clk); #1;
    total++;
    if (obs() !== 43'd0) begin
      bad++; $display("FAIL reset_init: got %h want 0", obs());
    end
    reset = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_back_pressure();
    test_pointer_skip();
    test_counter_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_mux4_arbiter.md
Name: rr_mux4_arbiter

Overview:
- Round-robin arbiter and sequencer sharing one 4:1 WIDTH-bit mux datapath among four requesters.
- Picks one pending requester, drives the 2-bit select, and captures that requester's word into an output register.
- Presents the word downstream on a valid/ready handshake and holds the grant until it is accepted.
- Sits between four producer blocks and a single consumer, in place of a free-running mux select.

Parameters:
- WIDTH, 32, data width of each requester word and of out_data.
- CNT_W, 16, width of the accepted-transfer counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req  input  4  req[i] high = requester i has a word pending on d_i.
- d0  input  WIDTH  requester 0 data, must be stable while req[0] high.
- d1  input  WIDTH  requester 1 data.
- d2  input  WIDTH  requester 2 data.
- d3  input  WIDTH  requester 3 data.
- gnt  output  4  one-hot, one-cycle pulse: requester's word was captured.
- sel  output  2  mux select of the current/last captured requester.
- out_valid  output  1  out_data holds an unaccepted word.
- out_data  output  WIDTH  captured word.
- out_ready  input  1  consumer accepts when out_valid and out_ready are both high at a clock edge.
- xfer_cnt  output  CNT_W  number of accepted transfers, wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, immediate, any state):
  - state=IDLE, ptr=0, sel=0, gnt=0, out_valid=0, out_data=0, xfer_cnt=0.
  - Any word in flight is dropped; no gnt is issued for it.
- Eligible set: req[i] & ~gnt[i]. A requester whose gnt pulse is high this cycle is not re-arbitrated. Requesters must drop req (or present new data) in the gnt cycle.
- Winner: the first eligible index scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- Capture event, at a clock edge:
  - sel<=winner, out_data<=d_winner, out_valid<=1.
  - gnt<=one-hot(winner) for exactly the next cycle.
  - ptr<=winner+1 mod 4.
- IDLE (out_valid=0):
  - Any eligible request: capture and go to BUSY. Latency from req rising to out_valid is 1 clock.
  - Otherwise stay; gnt=0.
- BUSY (out_valid=1):
  - out_data and sel are held stable; no new capture while out_ready is low. This back-pressure may last any number of cycles.
  - Accept (out_ready=1): xfer_cnt<=xfer_cnt+1.
    - If any requester is eligible in the same cycle, capture it in the same edge and stay in BUSY. Back-to-back transfers run at 1 word/clock.
    - Otherwise out_valid<=0 and go to IDLE; sel and out_data keep their last values.
- gnt is 0 in every cycle not immediately following a capture.
- Fairness: with all four requesting continuously, the grant order is 0,1,2,3,0,... Each requester waits at most 3 other transfers.
- xfer_cnt: from 2^CNT_W-1 it wraps to 0. It counts accepts only, not captures.
- out_ready while out_valid=0 is ignored.
- req changes during BUSY affect only the next arbitration.

Test Plan:
- Reset mid-transfer:
  - Stimulus: req=4'b0010, d1=32'hDEADBEEF, out_ready=0; assert reset while BUSY.
  - Response: out_valid, gnt, out_data and xfer_cnt go to 0 immediately. After release with req=0, outputs stay 0.
- Single request:
  - Stimulus: req=4'b0100, d2=32'h12345678, out_ready=1.
  - Response: next edge gives sel=2, out_data=32'h12345678, gnt=4'b0100 for one cycle, out_valid=1.
  - Following edge: accepted, xfer_cnt=1, out_valid=0 when req is dropped.
- Round-robin:
  - Stimulus: req=4'b1111 held (each requester re-asserts after its gnt), out_ready=1, d_i=i+32'hA0.
  - Response: sel sequence 0,1,2,3,0 on consecutive cycles; out_data A0,A1,A2,A3,A0; xfer_cnt increments every cycle.
- Back-pressure:
  - Stimulus: capture d3=32'hCAFEF00D, then out_ready=0 for 5 cycles with req[0] high.
  - Response: out_valid=1, sel=3 and out_data=32'hCAFEF00D held; no gnt for 5 cycles.
  - On out_ready=1: word accepted, sel=0 captured in the same edge.
- Pointer skip:
  - Stimulus: after a grant to 1 (ptr=2), req=4'b0011.
  - Response: winner is 0 (2 and 3 idle, wrap to 0), then 1.
- Counter wrap:
  - Stimulus: CNT_W=4, 17 accepted transfers.
  - Response: xfer_cnt reads 15 after the 15th transfer, 0 after the 16th, 1 after the 17th.
